// File: rtl/cpu_pkg.sv
// Shared CPU definitions: divider state encoding and timing constants.
package cpu_pkg;

    localparam int unsigned DIV_WIDTH   = 32;
    localparam int unsigned DIV_LATENCY = DIV_WIDTH + 3;

    typedef enum logic [2:0] {
        DIV_IDLE,
        DIV_PREP,
        DIV_ITER,
        DIV_FIX,
        DIV_DONE
    } div_state_t;

endpackage

// File: rtl/div_unit_if.sv
// Control-unit <-> divider handshake and result bus.
interface div_unit_if
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
);
    logic             Start;
    logic             Signed;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic             DivZero;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (
        output Start, Signed, A, B,
        input  Busy, Done, DivZero, Hi, Lo
    );

    modport slave (
        input  Start, Signed, A, B,
        output Busy, Done, DivZero, Hi, Lo
    );
endinterface

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift {rem,quo} left, subtract divisor if it fits.
module div_step
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH:0]   dvs,
    output logic [WIDTH:0]   rem_n,
    output logic [WIDTH-1:0] quo_n
);
    logic [WIDTH+1:0] rem_sh;

    always_comb begin
        rem_sh = {rem, quo[WIDTH-1]};
        rem_n  = rem_sh[WIDTH:0];
        quo_n  = {quo[WIDTH-2:0], 1'b0};
        if (rem_sh >= {1'b0, dvs}) begin
            rem_n    = (WIDTH+1)'(rem_sh - {1'b0, dvs});
            quo_n[0] = 1'b1;
        end
    end
endmodule

// File: rtl/div_unit.sv
// Multicycle DIV/DIVU unit: sign-magnitude wrapper around a restoring divider.
module div_unit
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input logic       Clk,
    input logic       Reset,
    div_unit_if.slave bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_t       state, state_n;
    logic             sgn_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             neg_q, neg_r;
    logic [WIDTH:0]   rem, dvs, rem_n;
    logic [WIDTH-1:0] quo, quo_n;
    logic [CNT_W-1:0] cnt;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem   (rem),
        .quo   (quo),
        .dvs   (dvs),
        .rem_n (rem_n),
        .quo_n (quo_n)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= DIV_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n  = state;
        bus.Busy = 1'b0;
        bus.Done = 1'b0;
        unique case (state)
            DIV_IDLE: if (bus.Start) state_n = (bus.B == '0) ? DIV_DONE : DIV_PREP;
            DIV_PREP: begin
                bus.Busy = 1'b1;
                state_n  = DIV_ITER;
            end
            DIV_ITER: begin
                bus.Busy = 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) state_n = DIV_FIX;
            end
            DIV_FIX: begin
                bus.Busy = 1'b1;
                state_n  = DIV_DONE;
            end
            DIV_DONE: begin
                bus.Done = 1'b1;
                state_n  = DIV_IDLE;
            end
            default: state_n = DIV_IDLE;
        endcase
    end

    // Operands are captured raw at Start so later bus changes cannot leak into PREP.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sgn_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            rem         <= '0;
            dvs         <= '0;
            quo         <= '0;
            cnt         <= '0;
            bus.DivZero <= 1'b0;
            bus.Hi      <= '0;
            bus.Lo      <= '0;
        end else begin
            case (state)
                DIV_IDLE: if (bus.Start) begin
                    sgn_q       <= bus.Signed;
                    a_q         <= bus.A;
                    b_q         <= bus.B;
                    bus.DivZero <= (bus.B == '0);
                end
                DIV_PREP: begin
                    quo   <= (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
                    dvs   <= {1'b0, ((sgn_q && b_q[WIDTH-1]) ? -b_q : b_q)};
                    neg_q <= sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    neg_r <= sgn_q & a_q[WIDTH-1];
                    rem   <= '0;
                    cnt   <= '0;
                end
                DIV_ITER: begin
                    rem <= rem_n;
                    quo <= quo_n;
                    cnt <= cnt + 1'b1;
                end
                DIV_FIX: begin
                    bus.Lo <= neg_q ? -quo : quo;
                    bus.Hi <= neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized ops vs. an arithmetic model.
module tb_div_unit;
    import cpu_pkg::*;

    localparam int unsigned W = DIV_WIDTH;

    logic Clk = 1'b0;
    logic Reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    div_unit_if #(.WIDTH(W)) bus ();

    div_unit #(.WIDTH(W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Truncating division; remainder follows the dividend sign (plain 64-bit arithmetic).
    function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, lq, lr;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        lq = sa / sb;
        lr = sa % sb;
        q  = lq[31:0];
        r  = lr[31:0];
    endfunction

    // Issues one Start, scrambles the operand bus afterwards, waits for Done (bounded).
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_bad);
        @(posedge Clk); #1;
        bus.Start = 1'b1; bus.Signed = s; bus.A = a; bus.B = b;
        @(posedge Clk); #1;
        bus.Start = 1'b0; bus.A = $urandom; bus.B = $urandom; bus.Signed = 1'($urandom);
        lat = 1; busy_bad = 0;
        while (!bus.Done && lat < 100) begin
            if (bus.Busy !== 1'b1) busy_bad++;
            @(posedge Clk); #1;
            lat++;
        end
        if (bus.Busy !== 1'b0) busy_bad++;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        bus.Start = 1'b0; bus.Signed = 1'b0; bus.A = '0; bus.B = '0;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        @(posedge Clk); #1;
        n_checks++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.Busy); end
        n_checks++; if (bus.Done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.Done); end
        n_checks++; if (bus.DivZero !== 1'b0) begin n_fail++; $display("FAIL reset_divzero: got %b expected 0", bus.DivZero); end
        n_checks++; if (bus.Hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", bus.Hi); end
        n_checks++; if (bus.Lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", bus.Lo); end
    endtask

    task automatic test_divu_basic();
        int lat, bb;
        run_op(1'b0, 32'd100, 32'd7, lat, bb);
        n_checks++; if (lat != int'(DIV_LATENCY)) begin n_fail++; $display("FAIL divu_latency: got %0d expected %0d", lat, DIV_LATENCY); end
        n_checks++; if (bus.Lo !== 32'd14) begin n_fail++; $display("FAIL divu_lo: got %h expected %h", bus.Lo, 32'd14); end
        n_checks++; if (bus.Hi !== 32'd2) begin n_fail++; $display("FAIL divu_hi: got %h expected %h", bus.Hi, 32'd2); end
        n_checks++; if (bus.DivZero !== 1'b0) begin n_fail++; $display("FAIL divu_divzero: got %b expected 0", bus.DivZero); end
        n_checks++; if (bb != 0) begin n_fail++; $display("FAIL divu_busy: got %0d wrong cycles expected 0", bb); end
    endtask

    task automatic test_div_signed();
        int lat, bb;
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat, bb);
        n_checks++; if (bus.Lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL sdiv1_lo: got %h expected fffffffd", bus.Lo); end
        n_checks++; if (bus.Hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sdiv1_hi: got %h expected ffffffff", bus.Hi); end
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, lat, bb);
        n_checks++; if (bus.Lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL sdiv2_lo: got %h expected fffffffd", bus.Lo); end
        n_checks++; if (bus.Hi !== 32'd1) begin n_fail++; $display("FAIL sdiv2_hi: got %h expected 00000001", bus.Hi); end
        n_checks++; if (lat != int'(DIV_LATENCY)) begin n_fail++; $display("FAIL sdiv2_latency: got %0d expected %0d", lat, DIV_LATENCY); end
    endtask

    // Relies on the 7 / -2 result left behind by test_div_signed.
    task automatic test_div_zero();
        int lat, bb;
        run_op(1'b1, 32'd123, 32'd0, lat, bb);
        n_checks++; if (lat != 1) begin n_fail++; $display("FAIL dz_latency: got %0d expected 1", lat); end
        n_checks++; if (bus.DivZero !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b expected 1", bus.DivZero); end
        n_checks++; if (bus.Lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL dz_lo_hold: got %h expected fffffffd", bus.Lo); end
        n_checks++; if (bus.Hi !== 32'd1) begin n_fail++; $display("FAIL dz_hi_hold: got %h expected 00000001", bus.Hi); end
        n_checks++; if (bb != 0) begin n_fail++; $display("FAIL dz_busy: got %0d wrong cycles expected 0", bb); end
        repeat (3) @(posedge Clk);
        #1;
        n_checks++; if (bus.DivZero !== 1'b1) begin n_fail++; $display("FAIL dz_flag_held: got %b expected 1", bus.DivZero); end
        @(posedge Clk); #1;
        bus.Start = 1'b1; bus.Signed = 1'b0; bus.A = 32'd50; bus.B = 32'd6;
        @(posedge Clk); #1;
        bus.Start = 1'b0;
        n_checks++; if (bus.DivZero !== 1'b0) begin n_fail++; $display("FAIL dz_clear_on_start: got %b expected 0", bus.DivZero); end
        lat = 1;
        while (!bus.Done && lat < 100) begin @(posedge Clk); #1; lat++; end
        n_checks++; if (bus.Lo !== 32'd8 || bus.Hi !== 32'd2) begin n_fail++; $display("FAIL dz_next_op: got lo=%h hi=%h expected lo=8 hi=2", bus.Lo, bus.Hi); end
    endtask

    task automatic test_overflow();
        int lat, bb;
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bb);
        n_checks++; if (bus.Lo !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_div_lo: got %h expected 80000000", bus.Lo); end
        n_checks++; if (bus.Hi !== 32'h0) begin n_fail++; $display("FAIL ovf_div_hi: got %h expected 0", bus.Hi); end
        n_checks++; if (bus.DivZero !== 1'b0) begin n_fail++; $display("FAIL ovf_div_flag: got %b expected 0", bus.DivZero); end
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat, bb);
        n_checks++; if (bus.Lo !== 32'h0) begin n_fail++; $display("FAIL ovf_divu_lo: got %h expected 0", bus.Lo); end
        n_checks++; if (bus.Hi !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_divu_hi: got %h expected 80000000", bus.Hi); end
    endtask

    task automatic test_start_ignored();
        int lat, ndone, dlat;
        logic [31:0] lo, hi;
        ndone = 0; dlat = 0; lo = '0; hi = '0;
        @(posedge Clk); #1;
        bus.Start = 1'b1; bus.Signed = 1'b0; bus.A = 32'd1000; bus.B = 32'd9;
        @(posedge Clk); #1;
        bus.Start = 1'b0;
        lat = 1;
        while (lat < 80) begin
            if (bus.Done) begin
                ndone++;
                if (ndone == 1) begin dlat = lat; lo = bus.Lo; hi = bus.Hi; end
            end
            bus.Start = (lat == 12);
            if (lat == 12) begin bus.Signed = 1'b1; bus.A = 32'd55; bus.B = 32'd3; end
            @(posedge Clk); #1;
            lat++;
        end
        n_checks++; if (ndone != 1) begin n_fail++; $display("FAIL busy_start_done_count: got %0d expected 1", ndone); end
        n_checks++; if (dlat != int'(DIV_LATENCY)) begin n_fail++; $display("FAIL busy_start_latency: got %0d expected %0d", dlat, DIV_LATENCY); end
        n_checks++; if (lo !== 32'd111 || hi !== 32'd1) begin n_fail++; $display("FAIL busy_start_result: got lo=%h hi=%h expected lo=6f hi=1", lo, hi); end
    endtask

    task automatic test_back_to_back();
        int lat, bb, ndone;
        run_op(1'b0, 32'd5000, 32'd7, lat, bb);
        n_checks++; if (bus.Lo !== 32'd714 || bus.Hi !== 32'd2) begin n_fail++; $display("FAIL b2b_first: got lo=%h hi=%h expected lo=2ca hi=2", bus.Lo, bus.Hi); end
        bus.Start = 1'b1; bus.Signed = 1'b0; bus.A = 32'd9; bus.B = 32'd3;
        @(posedge Clk); #1;
        bus.Start = 1'b0;
        n_checks++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL b2b_start_in_done: got busy=%b expected 0", bus.Busy); end
        ndone = 0;
        repeat (40) begin
            @(posedge Clk); #1;
            if (bus.Done) ndone++;
        end
        n_checks++; if (ndone != 0) begin n_fail++; $display("FAIL b2b_spurious_done: got %0d expected 0", ndone); end
        run_op(1'b0, 32'd9, 32'd3, lat, bb);
        n_checks++; if (lat != int'(DIV_LATENCY) || bus.Lo !== 32'd3 || bus.Hi !== 32'd0) begin
            n_fail++; $display("FAIL b2b_second: got lat=%0d lo=%h hi=%h expected lat=%0d lo=3 hi=0", lat, bus.Lo, bus.Hi, DIV_LATENCY);
        end
    endtask

    task automatic test_reset_abort();
        int lat, bb, ndone;
        @(posedge Clk); #1;
        bus.Start = 1'b1; bus.Signed = 1'b0; bus.A = 32'd1000; bus.B = 32'd3;
        @(posedge Clk); #1;
        bus.Start = 1'b0;
        repeat (11) @(posedge Clk);
        #1 Reset = 1'b1;
        #1;
        n_checks++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", bus.Busy); end
        n_checks++; if (bus.Hi !== 32'h0 || bus.Lo !== 32'h0) begin n_fail++; $display("FAIL abort_hilo: got hi=%h lo=%h expected 0", bus.Hi, bus.Lo); end
        n_checks++; if (bus.DivZero !== 1'b0 || bus.Done !== 1'b0) begin n_fail++; $display("FAIL abort_flags: got dz=%b done=%b expected 0", bus.DivZero, bus.Done); end
        @(posedge Clk); #1 Reset = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(posedge Clk); #1;
            if (bus.Done) ndone++;
        end
        n_checks++; if (ndone != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d expected 0", ndone); end
        run_op(1'b1, 32'hFFFF_FF9C, 32'd7, lat, bb);
        n_checks++; if (lat != int'(DIV_LATENCY) || bus.Lo !== 32'hFFFF_FFF2 || bus.Hi !== 32'hFFFF_FFFE) begin
            n_fail++; $display("FAIL abort_fresh_op: got lat=%0d lo=%h hi=%h expected lat=%0d lo=fffffff2 hi=fffffffe", lat, bus.Lo, bus.Hi, DIV_LATENCY);
        end
    endtask

    task automatic test_random();
        int lat, bb;
        logic s;
        logic [31:0] a, b, eq, er, prev_lo, prev_hi;
        run_op(1'b0, 32'd77, 32'd10, lat, bb);
        prev_lo = 32'd7; prev_hi = 32'd7;
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom);
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1:       b = 32'd1;
                2:       b = 32'hFFFF_FFFF;
                3:       b = 32'($urandom_range(2, 20));
                default: b = $urandom;
            endcase
            run_op(s, a, b, lat, bb);
            if (b == 32'd0) begin
                eq = prev_lo; er = prev_hi;
                n_checks++; if (lat != 1 || bus.DivZero !== 1'b1) begin n_fail++; $display("FAIL rand_dz[%0d]: got lat=%0d dz=%b expected lat=1 dz=1", i, lat, bus.DivZero); end
            end else begin
                ref_div(s, a, b, eq, er);
                n_checks++; if (lat != int'(DIV_LATENCY) || bus.DivZero !== 1'b0) begin n_fail++; $display("FAIL rand_timing[%0d]: got lat=%0d dz=%b expected lat=%0d dz=0", i, lat, bus.DivZero, DIV_LATENCY); end
            end
            n_checks++; if (bus.Lo !== eq || bus.Hi !== er) begin
                n_fail++; $display("FAIL rand_result[%0d]: s=%b a=%h b=%h got lo=%h hi=%h expected lo=%h hi=%h", i, s, a, b, bus.Lo, bus.Hi, eq, er);
            end
            prev_lo = eq; prev_hi = er;
        end
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_div_signed();
        test_div_zero();
        test_overflow();
        test_start_ignored();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
